uart_rx_pkt_ctrl: RTL and testbench

Sequencer downstream of the UART receiver. Consumes the receiver's byte stream (one-cycle valid strobe, data, parity-error flag) and parses framed command packets: SOF, LEN, payload, checksum. Accepted payload bytes are stored in an internal buffer, which is presented to the command decoder through a valid/ready handshake and a random-access read port. Malformed, corrupted or stalled frames are rejected with a coded error pulse.

---
 rtl/uart_rx_pkt_ctrl_if.sv | 29 ++
 rtl/uart_rx_pkt_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkt_ctrl_if.sv
// Bus bundle between the UART byte stream, the packet sequencer and the command decoder.
interface uart_rx_pkt_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_perr;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [LW-1:0] pkt_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          err_pulse;
  logic [2:0]    err_code;

  modport master (
    output rx_valid, rx_data, rx_perr, pkt_ready, rd_addr,
    input  pkt_valid, pkt_len, rd_data, busy, err_pulse, err_code
  );

  modport slave (
    input  rx_valid, rx_data, rx_perr, pkt_ready, rd_addr,
    output pkt_valid, pkt_len, rd_data, busy, err_pulse, err_code
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Parses SOF/LEN/payload/checksum frames from the UART receiver into a held payload buffer.
// state   | meaning
// IDLE    | hunting for SOF
// LEN     | waiting for length byte
// PAYLOAD | storing payload bytes
// CHK     | waiting for checksum byte
// HOLD    | good packet presented, waiting for consumer
module uart_rx_pkt_ctrl #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input logic clk,
  input logic rst_n,
  uart_rx_pkt_ctrl_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [2:0] E_PARITY  = 3'd0;
  localparam logic [2:0] E_LEN     = 3'd1;
  localparam logic [2:0] E_CHKSUM  = 3'd2;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_OVERRUN = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic          busy_q, busy_d;
  logic          err_pulse_q, err_pulse_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          wr_en;
  logic          tmo_hit;
  logic          active_d;
  logic [7:0]    buf_mem [MAX_LEN];

  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign active_d = (state_d == S_LEN) || (state_d == S_PAYLOAD) || (state_d == S_CHK);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    pkt_valid_d = pkt_valid_q;
    pkt_len_d   = pkt_len_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_perr) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_PARITY;
          end else if (bus.rx_data == SOF_BYTE) begin
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          state_d = S_IDLE;
          if (bus.rx_perr) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_PARITY;
          end else if (bus.rx_data == 8'd0 || int'(bus.rx_data) > MAX_LEN) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_LEN;
          end else begin
            len_d   = LW'(bus.rx_data);
            sum_d   = bus.rx_data;
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_TIMEOUT;
          state_d     = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          if (bus.rx_perr) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_PARITY;
            state_d     = S_IDLE;
          end else begin
            wr_en = 1'b1;
            sum_d = sum_q + bus.rx_data;
            idx_d = idx_q + LW'(1);
            if (idx_d == len_q) state_d = S_CHK;
          end
        end else if (tmo_hit) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_TIMEOUT;
          state_d     = S_IDLE;
        end
      end
      S_CHK: begin
        if (bus.rx_valid) begin
          state_d = S_IDLE;
          if (bus.rx_perr) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_PARITY;
          end else if (bus.rx_data != sum_q) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_CHKSUM;
          end else begin
            state_d     = S_HOLD;
            pkt_valid_d = 1'b1;
            pkt_len_d   = len_q;
          end
        end else if (tmo_hit) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_TIMEOUT;
          state_d     = S_IDLE;
        end
      end
      S_HOLD: begin
        // Bytes arriving while a packet is held are dropped, even on the release cycle.
        if (bus.rx_valid) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_OVERRUN;
        end
        if (bus.pkt_ready) begin
          pkt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.rx_valid || !active_d || state_q == S_IDLE) tmo_d = '0;
    else                                                 tmo_d = tmo_q + TW'(1);
    busy_d = active_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_len_q   <= '0;
      busy_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_len_q   <= pkt_len_d;
      busy_q      <= busy_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[idx_q[AW-1:0]] <= bus.rx_data;
  end

  assign bus.rd_data   = (int'(bus.rd_addr) < MAX_LEN) ? buf_mem[bus.rd_addr] : 8'h00;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.busy      = busy_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: frame-level queue model checked every cycle plus literal pins.
module tb_uart_rx_pkt_ctrl;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         TC      = 20;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;
  int   cyc;
  int   last_strobe;

  uart_rx_pkt_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_rx_pkt_ctrl #(.MAX_LEN(MAX_LEN), .SOF_BYTE(SOF), .TIMEOUT_CYC(TC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: bytes after SOF are queued; the frame is judged from the queue contents.
  logic       m_open, m_held, m_ep;
  logic [2:0] m_ec;
  int         m_len, m_gap;
  logic [7:0] m_q [$];
  logic [7:0] m_buf [MAX_LEN];
  logic [7:0] m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 0; m_held = 0; m_ep = 0; m_ec = 0; m_len = 0; m_gap = 0;
      m_q.delete();
    end else begin
      m_ep = 0;
      if (m_held) begin
        if (bus.rx_valid) begin m_ep = 1; m_ec = 3'd4; end
        if (bus.pkt_ready) m_held = 0;
      end else if (bus.rx_valid) begin
        m_gap = 0;
        if (bus.rx_perr) begin
          m_ep = 1; m_ec = 3'd0; m_open = 0;
        end else if (!m_open) begin
          if (bus.rx_data == SOF) begin m_open = 1; m_q.delete(); end
        end else begin
          m_q.push_back(bus.rx_data);
          if (m_q.size() == 1 && (bus.rx_data == 0 || int'(bus.rx_data) > MAX_LEN)) begin
            m_ep = 1; m_ec = 3'd1; m_open = 0;
          end else if (m_q.size() == int'(m_q[0]) + 2) begin
            m_sum = 8'h00;
            for (int i = 0; i <= int'(m_q[0]); i++) m_sum = m_sum + m_q[i];
            if (m_sum == bus.rx_data) begin
              m_held = 1;
              m_len  = int'(m_q[0]);
              for (int i = 0; i < m_len; i++) m_buf[i] = m_q[i+1];
            end else begin
              m_ep = 1; m_ec = 3'd2;
            end
            m_open = 0;
          end
        end
      end else if (m_open) begin
        m_gap++;
        if (m_gap == TC) begin m_ep = 1; m_ec = 3'd3; m_open = 0; end
      end
    end
  end

  always @(negedge clk) begin
    check("pkt_valid", 32'(bus.pkt_valid), 32'(m_held));
    check("busy", 32'(bus.busy), 32'(m_open));
    check("err_pulse", 32'(bus.err_pulse), 32'(m_ep));
    check("err_code", 32'(bus.err_code), 32'(m_ec));
    if (m_held) begin
      check("pkt_len", 32'(bus.pkt_len), 32'(m_len));
      if (int'(bus.rd_addr) < m_len) check("rd_data", 32'(bus.rd_data), 32'(m_buf[bus.rd_addr]));
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic p = 1'b0);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_perr = p;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_perr = 1'b0;
    last_strobe = cyc;
  endtask

  task automatic send_frame(input logic [7:0] b [$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic release_pkt();
    @(posedge clk); #1 bus.pkt_ready = 1'b1;
    @(posedge clk); #1 bus.pkt_ready = 1'b0;
    check("released_valid", 32'(bus.pkt_valid), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [7:0] fr [$];
    logic [7:0] s;
    int c1;
    bit seen;
    n_checks = 0; n_errs = 0; cyc = 0; last_strobe = 0;
    rst_n = 1'b0;
    bus.rx_valid = 0; bus.rx_data = 0; bus.rx_perr = 0; bus.pkt_ready = 0; bus.rd_addr = 0;
    idle(3); #1;
    check("rst_valid", 32'(bus.pkt_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err_pulse", 32'(bus.err_pulse), 0);
    check("rst_err_code", 32'(bus.err_code), 0);
    check("rst_pkt_len", 32'(bus.pkt_len), 0);
    rst_n = 1'b1;

    // good frame; checksum covers LEN: 03+11+22+33 = 69
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33});
    check("mid_busy", 32'(bus.busy), 1);
    check("mid_valid", 32'(bus.pkt_valid), 0);
    send_byte(8'h69);
    check("good_valid", 32'(bus.pkt_valid), 1);
    check("good_busy", 32'(bus.busy), 0);
    check("good_len", 32'(bus.pkt_len), 3);
    bus.rd_addr = 0; #1 check("good_rd0", 32'(bus.rd_data), 32'h11);
    bus.rd_addr = 1; #1 check("good_rd1", 32'(bus.rd_data), 32'h22);
    bus.rd_addr = 2; #1 check("good_rd2", 32'(bus.rd_data), 32'h33);
    release_pkt();

    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    check("lenless_sum_err", 32'(bus.err_code), 2);

    send_frame('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04});
    check("badsum_pulse", 32'(bus.err_pulse), 1);
    check("badsum_code", 32'(bus.err_code), 2);
    check("badsum_valid", 32'(bus.pkt_valid), 0);
    check("badsum_busy", 32'(bus.busy), 0);
    send_frame('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05});
    check("after_bad_valid", 32'(bus.pkt_valid), 1);
    check("after_bad_len", 32'(bus.pkt_len), 2);
    send_byte(8'h5A);
    check("overrun_pulse", 32'(bus.err_pulse), 1);
    check("overrun_code", 32'(bus.err_code), 4);
    check("overrun_valid", 32'(bus.pkt_valid), 1);
    bus.rd_addr = 1; #1 check("overrun_rd1", 32'(bus.rd_data), 32'h02);
    release_pkt();

    send_frame('{8'hA5, 8'h00});
    check("len0_code", 32'(bus.err_code), 1);
    send_frame('{8'hA5, 8'h11});
    check("len17_code", 32'(bus.err_code), 1);
    check("len17_pulse", 32'(bus.err_pulse), 1);
    fr = '{8'hA5, 8'h10};
    s = 8'h10;
    for (int i = 0; i < 16; i++) begin fr.push_back(8'(i * 3)); s = s + 8'(i * 3); end
    fr.push_back(s);
    send_frame(fr);
    check("len16_sum_pin", 32'(s), 32'h78);
    check("len16_len", 32'(bus.pkt_len), 16);
    bus.rd_addr = 15; #1 check("len16_rd15", 32'(bus.rd_data), 32'h2D);
    release_pkt();

    send_frame('{8'hA5, 8'h02, 8'h11});
    c1 = last_strobe; seen = 0;
    for (int i = 0; i < 3 * TC && !seen; i++) begin
      @(negedge clk);
      if (bus.err_pulse) begin seen = 1; c1 = cyc - last_strobe; end
    end
    check("tmo_seen", 32'(seen), 1);
    check("tmo_delay", 32'(c1), TC);
    check("tmo_code", 32'(bus.err_code), 3);
    check("tmo_busy", 32'(bus.busy), 0);

    send_frame('{8'hA5, 8'h02, 8'h11});
    idle(TC - 2);
    send_byte(8'h22);
    check("tc_byte_no_pulse", 32'(bus.err_pulse), 0);
    check("tc_byte_busy", 32'(bus.busy), 1);
    send_byte(8'h35);
    check("tc_frame_valid", 32'(bus.pkt_valid), 1);
    release_pkt();

    send_frame('{8'hA5, 8'h02});
    send_byte(8'h11, 1'b1);
    check("perr_pulse", 32'(bus.err_pulse), 1);
    check("perr_code", 32'(bus.err_code), 0);
    check("perr_busy", 32'(bus.busy), 0);

    send_frame('{8'hA5, 8'h01, 8'h05, 8'h00});
    send_frame('{8'hA5, 8'h04, 8'h01, 8'h02});
    rst_n = 1'b0;
    #3;
    check("mrst_valid", 32'(bus.pkt_valid), 0);
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_code", 32'(bus.err_code), 0);
    check("mrst_len", 32'(bus.pkt_len), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_frame('{8'hA5, 8'h01, 8'h7F, 8'h80});
    check("post_rst_valid", 32'(bus.pkt_valid), 1);
    check("post_rst_len", 32'(bus.pkt_len), 1);
    bus.rd_addr = 0; #1 check("post_rst_rd0", 32'(bus.rd_data), 32'h7F);
    release_pkt();

    idle(3);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
